// File: rtl/thresholding_bsearch_axis.sv
// Streaming multi-threshold unit: a pipelined binary search over a programmable
// per-channel threshold table. Input register, N compare stages, last one is the output register.
module thresholding_bsearch_axis #(
    parameter int N      = 4,
    parameter int K      = 16,
    parameter int C      = 8,
    parameter int PE     = 2,
    parameter int SIGNED = 1,
    parameter int BIAS   = 0,
    parameter int SHARED = 0,
    localparam int CS     = (SHARED != 0) ? 1 : C,
    localparam int AW     = $clog2(CS) + N,
    localparam int O_BITS = $clog2(2**N + BIAS),
    localparam int IW     = ((PE*K + 7) / 8) * 8,
    localparam int OW     = ((PE*O_BITS + 7) / 8) * 8
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [AW-1:0] cfg_addr,
    input  logic [K-1:0]  cfg_data,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [IW-1:0] s_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [OW-1:0] m_axis_tdata,
    output logic          m_axis_tlast
);

    localparam int CF  = C / PE;
    localparam int NT  = 2**N - 1;
    localparam int FW  = (CF > 1) ? $clog2(CF) : 1;
    localparam int CHW = (CS > 1) ? $clog2(CS) : 1;

    logic [K-1:0]  thr [CS][NT];

    logic          adv;
    logic          in_fire;
    logic          cfg_fire;
    logic          wr_en;
    logic [N-1:0]  wr_idx;
    logic [31:0]   wr_ch;
    logic [FW-1:0] fold;

    logic [N-1:0]  v_q;
    logic [N-1:0]  last_q;
    logic [FW-1:0] fold_q [N];
    logic [K-1:0]  x_q    [N][PE];
    logic [N-1:0]  idx_q  [N][PE];
    logic [N-1:0]  idx_nx [N][PE];
    logic [OW-1:0] out_nx;

    logic [CHW-1:0] ch;
    logic [N-1:0]   step;
    logic [N-1:0]   ti;
    logic [K-1:0]   t;
    logic           ge;

    assign adv           = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = adv && !cfg_valid;
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign cfg_ready     = !(|v_q) && !m_axis_tvalid;

    // Writes only land once the pipeline is empty, so no beat sees a mixed table.
    assign cfg_fire = cfg_valid && cfg_ready;
    assign wr_idx   = cfg_addr[N-1:0];
    assign wr_ch    = 32'(cfg_addr >> N);
    assign wr_en    = cfg_fire && (wr_idx != N'(NT)) && (wr_ch < 32'(CS));

    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            thr[CHW'(wr_ch)][wr_idx] <= cfg_data;
        end
    end

    always_comb begin
        ch     = '0;
        step   = '0;
        ti     = '0;
        t      = '0;
        ge     = 1'b0;
        out_nx = '0;
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < PE; i++) begin
                ch   = (SHARED != 0) ? '0
                     : CHW'(32'(fold_q[s]) * 32'(PE) + 32'(i));
                step = N'(1) << (N - 1 - s);
                ti   = idx_q[s][i] + step - N'(1);
                t    = thr[ch][ti];
                if (SIGNED != 0) begin
                    ge = $signed(x_q[s][i]) >= $signed(t);
                end else begin
                    ge = x_q[s][i] >= t;
                end
                idx_nx[s][i] = idx_q[s][i] + (ge ? step : '0);
            end
        end
        for (int i = 0; i < PE; i++) begin
            out_nx[i*O_BITS +: O_BITS] = O_BITS'(idx_nx[N-1][i])
                                       + O_BITS'(BIAS);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v_q           <= '0;
            last_q        <= '0;
            fold          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            for (int s = 0; s < N; s++) begin
                fold_q[s] <= '0;
                for (int i = 0; i < PE; i++) begin
                    x_q[s][i]   <= '0;
                    idx_q[s][i] <= '0;
                end
            end
        end else if (adv) begin
            v_q[0]    <= in_fire;
            last_q[0] <= (fold == FW'(CF - 1));
            fold_q[0] <= fold;
            for (int i = 0; i < PE; i++) begin
                x_q[0][i]   <= s_axis_tdata[i*K +: K];
                idx_q[0][i] <= '0;
            end
            for (int s = 1; s < N; s++) begin
                v_q[s]    <= v_q[s-1];
                last_q[s] <= last_q[s-1];
                fold_q[s] <= fold_q[s-1];
                for (int i = 0; i < PE; i++) begin
                    x_q[s][i]   <= x_q[s-1][i];
                    idx_q[s][i] <= idx_nx[s-1][i];
                end
            end
            m_axis_tvalid <= v_q[N-1];
            if (v_q[N-1]) begin
                m_axis_tdata <= out_nx;
                m_axis_tlast <= last_q[N-1];
            end
            if (in_fire) begin
                fold <= (fold == FW'(CF - 1)) ? '0 : fold + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_thresholding_bsearch_axis.sv
// Scoreboard bench: instance A (signed, 2 channels, PE=1) and
// instance B (shared table, unsigned, BIAS=2, PE=2).
module tb_thresholding_bsearch_axis;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cfg_valid_a = 0, cfg_ready_a;
    logic [2:0] cfg_addr_a = 0;
    logic [7:0] cfg_data_a = 0;
    logic       s_tvalid_a = 0, s_tready_a;
    logic [7:0] s_tdata_a = 0;
    logic       m_tvalid_a, m_tready_a = 1, m_tlast_a;
    logic [7:0] m_tdata_a;

    logic        cfg_valid_b = 0, cfg_ready_b;
    logic [1:0]  cfg_addr_b = 0;
    logic [7:0]  cfg_data_b = 0;
    logic        s_tvalid_b = 0, s_tready_b;
    logic [15:0] s_tdata_b = 0;
    logic        m_tvalid_b, m_tready_b = 1, m_tlast_b;
    logic [7:0]  m_tdata_b;

    thresholding_bsearch_axis #(
        .N(2), .K(8), .C(2), .PE(1), .SIGNED(1), .BIAS(0), .SHARED(0)
    ) dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
        .cfg_addr(cfg_addr_a), .cfg_data(cfg_data_a),
        .s_axis_tvalid(s_tvalid_a), .s_axis_tready(s_tready_a),
        .s_axis_tdata(s_tdata_a),
        .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_tready_a),
        .m_axis_tdata(m_tdata_a), .m_axis_tlast(m_tlast_a)
    );

    thresholding_bsearch_axis #(
        .N(2), .K(8), .C(2), .PE(2), .SIGNED(0), .BIAS(2), .SHARED(1)
    ) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .cfg_addr(cfg_addr_b), .cfg_data(cfg_data_b),
        .s_axis_tvalid(s_tvalid_b), .s_axis_tready(s_tready_b),
        .s_axis_tdata(s_tdata_b),
        .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready_b),
        .m_axis_tdata(m_tdata_b), .m_axis_tlast(m_tlast_b)
    );

    int tests = 0;
    int fails = 0;
    int popped_a = 0;
    logic [8:0] sb_a[$];
    logic [8:0] sb_b[$];
    logic [8:0] ea, eb;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_tvalid_a && m_tready_a) begin
            popped_a++;
            if (sb_a.size() == 0) begin
                check("a_extra_beat", 1, 0);
            end else begin
                ea = sb_a.pop_front();
                check("a_data", int'(m_tdata_a), int'(ea[7:0]));
                check("a_last", int'(m_tlast_a), int'(ea[8]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_tvalid_b && m_tready_b) begin
            if (sb_b.size() == 0) begin
                check("b_extra_beat", 1, 0);
            end else begin
                eb = sb_b.pop_front();
                check("b_data", int'(m_tdata_b), int'(eb[7:0]));
                check("b_last", int'(m_tlast_b), int'(eb[8]));
            end
        end
    end

    task automatic cfg_a(input logic [2:0] a, input logic [7:0] d);
        int n = 0;
        cfg_addr_a = a; cfg_data_a = d; cfg_valid_a = 1;
        do begin @(negedge clk); n++; end while (!cfg_ready_a && n < 50);
        if (!cfg_ready_a) check("a_cfg_timeout", 0, 1);
        @(posedge clk); #1;
        cfg_valid_a = 0;
    endtask

    task automatic cfg_b(input logic [1:0] a, input logic [7:0] d);
        int n = 0;
        cfg_addr_b = a; cfg_data_b = d; cfg_valid_b = 1;
        do begin @(negedge clk); n++; end while (!cfg_ready_b && n < 50);
        if (!cfg_ready_b) check("b_cfg_timeout", 0, 1);
        @(posedge clk); #1;
        cfg_valid_b = 0;
    endtask

    task automatic send_a(input logic [7:0] x, input logic [1:0] ex,
                          input logic lst);
        int n = 0;
        s_tdata_a = x; s_tvalid_a = 1;
        do begin @(negedge clk); n++; end while (!s_tready_a && n < 100);
        if (!s_tready_a) check("a_send_timeout", 0, 1);
        @(posedge clk); #1;
        sb_a.push_back({lst, 6'd0, ex});
    endtask

    task automatic send_b(input logic [15:0] x, input logic [7:0] ex);
        int n = 0;
        s_tdata_b = x; s_tvalid_b = 1;
        do begin @(negedge clk); n++; end while (!s_tready_b && n < 100);
        if (!s_tready_b) check("b_send_timeout", 0, 1);
        @(posedge clk); #1;
        sb_b.push_back({1'b1, ex});
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 100) begin
            @(posedge clk); n++;
        end
        check("drain_empty", sb_a.size() + sb_b.size(), 0);
        #1;
    endtask

    // ch0 {-5,0,7}, ch1 {10,20,30}; folds alternate ch0/ch1
    int v1x[14] = '{-6, 5, -5, 10, 0, 25, 6, 30, 7, -128, 100, 127, 15, 15};
    int v1e[14] = '{ 0, 0,  1,  1, 2,  2, 2,  3, 3,    0,   3,   3,  3,  1};
    int bpx[8]  = '{-6, 35, 1, 19, -1, 20, 8, 9};
    int bpe[8]  = '{ 0,  3, 2,  1,  1,  2, 3, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n, p0, stable;
        logic [7:0] d0;
        logic seen;
        #2;
        check("rst_a_tvalid", int'(m_tvalid_a), 0);
        check("rst_a_tdata", int'(m_tdata_a), 0);
        check("rst_a_tlast", int'(m_tlast_a), 0);
        check("rst_b_tvalid", int'(m_tvalid_b), 0);
        check("rst_b_tdata", int'(m_tdata_b), 0);
        #20 rst_n = 1;
        @(posedge clk); #1;

        cfg_b(2'd0, 8'd1); cfg_b(2'd1, 8'd2); cfg_b(2'd2, 8'd3);
        send_b({8'd255, 8'd0}, 8'h2A);
        send_b({8'd1, 8'd2}, 8'h1C);
        s_tvalid_b = 0;
        drain();
        cfg_b(2'd3, 8'd0);
        send_b({8'd255, 8'd0}, 8'h2A);
        s_tvalid_b = 0;
        drain();

        cfg_a(3'b000, 8'(-5)); cfg_a(3'b001, 8'd0); cfg_a(3'b010, 8'd7);
        cfg_a(3'b100, 8'd10);  cfg_a(3'b101, 8'd20); cfg_a(3'b110, 8'd30);

        send_a(8'(v1x[0]), 2'(v1e[0]), 1'b0);
        s_tvalid_a = 0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (m_tvalid_a) break;
            @(posedge clk); lat++;
        end
        check("a_latency", lat, N + 1);
        @(posedge clk); #1;
        for (int i = 1; i < 14; i++) send_a(8'(v1x[i]), 2'(v1e[i]), i % 2 == 1);
        s_tvalid_a = 0;
        drain();

        m_tready_a = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_a(8'(bpx[i]), 2'(bpe[i]), i % 2 == 1);
                s_tvalid_a = 0;
            end
            begin
                seen = 0; stable = 1; d0 = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (m_tvalid_a && !seen) begin
                        d0 = m_tdata_a; seen = 1;
                    end else if (m_tvalid_a && m_tdata_a != d0) begin
                        stable = 0;
                    end
                end
                check("bp_s_tready_low", int'(s_tready_a), 0);
                check("bp_tvalid_held", int'(m_tvalid_a), 1);
                check("bp_data_stable", stable, 1);
                @(posedge clk); #1;
                m_tready_a = 1;
                p0 = popped_a; n = 0;
                while (popped_a - p0 < 8 && n < 40) begin
                    @(posedge clk); n++;
                end
                check("bp_all_out", popped_a - p0, 8);
                check("bp_rate_ok", int'(n <= 9), 1);
            end
        join
        drain();

        send_a(8'd10, 2'd3, 1'b0);
        send_a(8'd10, 2'd1, 1'b1);
        send_a(8'd10, 2'd3, 1'b0);
        s_tdata_a = 8'd10;
        cfg_addr_a = 3'b010; cfg_data_a = 8'd60; cfg_valid_a = 1;
        @(negedge clk);
        check("drain_s_tready", int'(s_tready_a), 0);
        check("drain_cfg_busy", int'(cfg_ready_a), 0);
        n = 0;
        while (!cfg_ready_a && n < 50) begin @(negedge clk); n++; end
        check("drain_cfg_ready", int'(cfg_ready_a), 1);
        check("drain_beats_out", sb_a.size(), 0);
        @(posedge clk); #1;
        cfg_valid_a = 0;
        send_a(8'd10, 2'd1, 1'b1);
        send_a(8'd10, 2'd2, 1'b0);
        send_a(8'd31, 2'd3, 1'b1);
        s_tvalid_a = 0;
        drain();

        cfg_a(3'b011, 8'd0);
        send_a(8'd5, 2'd2, 1'b0);
        send_a(8'd30, 2'd3, 1'b1);
        send_a(8'(-6), 2'd0, 1'b0);
        s_tvalid_a = 0;
        drain();

        send_a(8'd25, 2'd2, 1'b1);
        send_a(8'd1, 2'd2, 1'b0);
        s_tvalid_a = 0;
        @(posedge clk); #1;
        check("rst_pre_valid", int'(m_tvalid_a), 1);
        rst_n = 0;
        sb_a.delete(); sb_b.delete();
        #1;
        check("rst_mid_tvalid", int'(m_tvalid_a), 0);
        check("rst_mid_tdata", int'(m_tdata_a), 0);
        check("rst_mid_tlast", int'(m_tlast_a), 0);
        check("rst_mid_cfg_ready", int'(cfg_ready_a), 1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        send_a(8'd10, 2'd2, 1'b0);
        send_a(8'd25, 2'd2, 1'b1);
        s_tvalid_a = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/thresholding_bsearch_axis.md
Name: thresholding_bsearch_axis

Overview:
Streaming multi-threshold unit. Maps each K-bit input lane to an N-bit count of the thresholds it meets or exceeds, plus a bias. The count is found by an N-stage pipelined binary search over a runtime-programmable per-channel threshold memory. It sits between AXI-Stream producers and consumers in the dataflow fabric. It generalises the fixed-table threshold core with:
- a shared-threshold mode;
- a drain-then-write configuration port;
- end-of-fold marking via tlast.

Parameters:
N, 4, output precision; 2^N-1 thresholds per channel
K, 16, input/threshold precision
C, 8, channel count
PE, 2, parallel lanes; C mod PE = 0; CF = C/PE
SIGNED, 1, 1: two's-complement compare; 0: unsigned compare
BIAS, 0, added to every output count; O_BITS = clog2(2^N+BIAS)
SHARED, 0, 1: one threshold set shared by all channels (CS=1); 0: per-channel sets (CS=C)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  threshold write request
cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
cfg_addr  in  clog2(CS)+N  {channel, threshold index}
cfg_data  in  K  threshold value
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  ((PE*K+7)/8)*8  lane i at [i*K +: K]
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tdata  out  ((PE*O_BITS+7)/8)*8  lane i at [i*O_BITS +: O_BITS]; pad bits 0
m_axis_tlast  out  1  high on beat carrying channel fold CF-1

Behaviour:
- Reset (async assert, sync deassert use):
  - all pipeline valid flags 0
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0
  - fold counter 0
  - cfg_ready=0 until the pipeline is empty
  - threshold memory is not cleared; its contents are undefined until written.
- Fold counter:
  - increments on each accepted input beat; wraps CF-1 -> 0
  - lane i of fold f uses channel f*PE+i, or channel 0 if SHARED
  - tlast = (fold == CF-1), carried through the pipeline with the data.
- Search:
  - idx starts at 0.
  - Stage s (0..N-1) uses step = 2^(N-1-s); if x >= T[ch][idx+step-1] then idx += step.
  - Compare is signed iff SIGNED.
  - Output = idx + BIAS (range BIAS..2^N-1+BIAS).
  - Thresholds must be programmed non-decreasing; if they are not, the result is the deterministic search path result, not an error.
- Pipeline and latency:
  - input register + N search stages + output register.
  - Global advance = !m_axis_tvalid || m_axis_tready.
  - All stages shift on advance, otherwise all hold.
  - Latency from input accept to m_axis_tvalid is N+1 cycles with no backpressure.
  - Throughput is 1 beat/cycle.
- Ready / hold rules:
  - s_axis_tready = advance && !cfg_valid.
  - m_axis_tdata/tlast stay stable while tvalid && !tready.
- Configuration:
  - cfg_ready = cfg_valid-independent, high only when no stage and no output register holds valid data.
  - While cfg_valid is high, input is blocked so the pipeline drains, then the write is accepted.
  - The write takes effect for the next accepted input beat.
  - Index 2^N-1 or channel >= CS: the handshake completes, memory is unchanged.
  - Simultaneous cfg_valid and s_axis_tvalid: config wins; no input is accepted in that cycle.
- Mid-operation reset: in-flight beats are discarded, the fold counter returns to 0, memory is retained.

Test Plan:
- Basic search: N=2, K=8, C=2, PE=1, SIGNED=1. Program ch0 thresholds {-5,0,7}. Inputs -6,-5,0,6,7,100 -> outputs 0,1,2,2,3,3, each 3 cycles after accept.
- Channels and tlast: program ch1 {10,20,30}, stream 15 on ch0 then 15 on ch1 -> outputs 3 then 1; tlast 0 then 1; fold wraps to ch0.
- Backpressure: hold m_axis_tready=0 for 10 cycles with continuous input -> s_axis_tready drops once the pipeline is full, output data stable, no loss or duplication; release -> in-order completion at 1 beat/cycle.
- Config drain: assert cfg_valid while 3 beats are in flight -> s_axis_tready=0 immediately; cfg_ready rises only after all 3 beats are output; beats use the old thresholds, later beats use the new ones.
- SHARED=1, BIAS=2, SIGNED=0, PE=2: one set {1,2,3}, lanes {0,255} -> {2,5}; write to index 3 -> handshake ok, results unchanged.
- Reset mid-stream: assert ap_rst_n=0 with 2 beats in flight -> m_axis_tvalid=0 at once; after release the first output has tlast matching fold 0; thresholds still valid.
